fifo_write_arbiter: RTL
=======================

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 SHALL take parameter W, default 6: data width, equal to the shared FIFO's w.
REQ-002 SHALL take parameter N, default 4: number of requesters, N ≥ 2.
REQ-003 SHALL take parameter BURST, default 4: maximum beats per grant, BURST ≥ 1.
REQ-004 SHALL use one clock, clk; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock, shared with the FIFO.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 req  input  N  per-requester "beat available".
REQ-008 last  input  N  per-requester "this beat ends my burst".
REQ-009 data_in  input  N×W  per-requester beat data.
REQ-010 fifo_full  input  1  full flag from the shared FIFO.
REQ-011 gnt  output  N  one-hot; beat of requester i accepted on this edge.
REQ-012 fifo_we  output  1  FIFO write enable.
REQ-013 fifo_data  output  W  FIFO write data.
REQ-014 busy  output  1  a burst is locked in progress.
REQ-015 owner  output  clog2(N)  index of current or last-granted requester.

Function
REQ-016 SHALL have two states: IDLE and LOCKED.
REQ-017 SHALL generate gnt, fifo_we and fifo_data combinationally from registered state and current inputs, with zero-cycle accept latency.
REQ-018 SHALL assert fifo_we iff gnt is non-zero; fifo_data = data_in[i] for the granted i, otherwise 0.
REQ-019 SHALL never assert gnt while fifo_full = 1; all state holds unchanged that cycle.
REQ-020 IDLE: grant the first requester with req = 1, searching from prio_ptr upward and wrapping modulo N.
REQ-021 IDLE grant to i: owner ← i, beat count ← 1; go to LOCKED unless last[i] = 1 or BURST = 1.
REQ-022 IDLE grant that does not lock: prio_ptr ← (i+1) mod N.
REQ-023 LOCKED: only req[owner] is eligible; other requesters get gnt = 0 regardless of req.
REQ-024 LOCKED beat accepted: count ← count+1; exit to IDLE if last[owner] = 1 or the new count = BURST.
REQ-025 LOCKED with req[owner] = 0 and fifo_full = 0: abandon the burst; go to IDLE next cycle with no beat written.
REQ-026 Every exit from LOCKED: prio_ptr ← (owner+1) mod N.
REQ-027 LOCKED with fifo_full = 1: hold state, count and owner, regardless of req[owner].
REQ-028 busy = 1 exactly in LOCKED.
REQ-029 Beat counter width: clog2(BURST+1); it SHALL never exceed BURST.
REQ-030 SHALL hold owner when no grant occurs.

Reset
REQ-031 While reset = 1: state IDLE, prio_ptr 0, owner 0, count 0; gnt, fifo_we, fifo_data and busy SHALL all be 0.
REQ-032 Reset mid-burst SHALL abort the burst with no beat written, and nothing is retained on release.
REQ-033 On the first cycle after release, arbitration SHALL start from requester 0.

Structure
REQ-034 The shared package fifo_arb_pkg SHALL hold the state enum (IDLE, LOCKED) and the default parameter values.
REQ-035 The round-robin search SHALL be a sub-module rr_picker (inputs req, ptr; outputs one-hot grant and valid).
REQ-036 SHALL contain no storage of data beats; all buffering belongs to the downstream FIFO.

Verification
REQ-037 reset=1 with req=4'b1111 -> gnt=0, fifo_we=0, busy=0; after release, first gnt=4'b0001.
REQ-038 req=4'b1111, last=4'b1111 for 4 cycles -> gnt sequence 0001, 0010, 0100, 1000; fifo_data matches each data_in.
REQ-039 req[2] only, last=0, BURST=4 -> four consecutive gnt=0100, busy high for three cycles, then IDLE with prio_ptr=3.
REQ-040 Requester 1 locked; fifo_full pulses high for 2 cycles mid-burst while req[0] is held -> gnt=0 both cycles, count held, burst resumes on requester 1.
REQ-041 Requester 3 locked after 2 beats drops req[3] -> no write that cycle, IDLE next cycle, next grant goes to requester 0.
REQ-042 reset asserted during beat 2 of a burst from requester 1 -> outputs 0 immediately; after release, req=4'b0010 grants requester 1 with count restarting at 1.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared definitions for the FIFO write arbiter slice.
//   - state_t        : arbiter FSM states (IDLE, LOCKED)
//   - DEFAULT_*      : default parameter values for the arbiter
//   - wrap_next()    : modulo-N increment used for round-robin pointers
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

    // IDLE searches for a new requester, LOCKED streams a burst from one owner.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int DEFAULT_W     = 6;
    localparam int DEFAULT_N     = 4;
    localparam int DEFAULT_BURST = 4;

    // Next index after idx, wrapping back to 0 at n.
    function automatic int wrap_next(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Round-robin search: grants the first asserted request found when scanning
// upward from ptr, wrapping modulo N.
// Ports:
//   req   [N-1:0]  input   request vector
//   ptr   [PW-1:0] input   index searched first (must be < N)
//   grant [N-1:0]  output  one-hot grant, zero when nothing requested
//   valid          output  at least one request was found
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          valid
);

    // Scan N positions starting at ptr; the first hit wins and masks the rest.
    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_write_arbiter
// Arbitrates N requesters onto one shared FIFO write port. Grants are
// round-robin; once a requester is granted it keeps the port for up to BURST
// beats (or until it flags last / drops req). Accept latency is zero: gnt,
// fifo_we and fifo_data are combinational from registered state and inputs.
// No data is buffered here.
// Ports:
//   clk        input            rising-edge clock shared with the FIFO
//   reset      input            asynchronous active-high reset
//   req        input  [N-1:0]   per-requester beat available
//   last       input  [N-1:0]   per-requester end-of-burst marker
//   data_in    input  [N*W-1:0] per-requester beat data, requester i at [i*W +: W]
//   fifo_full  input            FIFO cannot accept a write this cycle
//   gnt        output [N-1:0]   one-hot, beat of requester i accepted this edge
//   fifo_we    output           FIFO write enable
//   fifo_data  output [W-1:0]   FIFO write data
//   busy       output           a burst is locked in progress
//   owner      output [PW-1:0]  current or last-granted requester
// -----------------------------------------------------------------------------
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int W     = DEFAULT_W,
    parameter int N     = DEFAULT_N,
    parameter int BURST = DEFAULT_BURST
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N-1:0]           req,
    input  logic [N-1:0]           last,
    input  logic [N*W-1:0]         data_in,
    input  logic                   fifo_full,
    output logic [N-1:0]           gnt,
    output logic                   fifo_we,
    output logic [W-1:0]           fifo_data,
    output logic                   busy,
    output logic [$clog2(N)-1:0]   owner
);

    localparam int PW = $clog2(N);
    localparam int CW = $clog2(BURST + 1);

    state_t         state, state_n;
    logic [PW-1:0]  prio_ptr, prio_ptr_n;
    logic [PW-1:0]  owner_q, owner_n;
    logic [CW-1:0]  count, count_n;
    logic [CW-1:0]  count_inc;

    logic [N-1:0]   pick_grant;
    logic           pick_valid;
    logic [PW-1:0]  pick_idx;

    rr_picker #(
        .N  (N),
        .PW (PW)
    ) u_picker (
        .req   (req),
        .ptr   (prio_ptr),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    // Convert the picker's one-hot grant into an index for owner/pointer updates.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_grant[i]) begin
                pick_idx = PW'(i);
            end
        end
    end

    // Only meaningful in LOCKED, where count < BURST so the increment cannot wrap.
    assign count_inc = count + CW'(1);

    // State register; reset aborts any burst and restarts the search at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            prio_ptr <= '0;
            owner_q  <= '0;
            count    <= '0;
        end else begin
            state    <= state_n;
            prio_ptr <= prio_ptr_n;
            owner_q  <= owner_n;
            count    <= count_n;
        end
    end

    // Next-state and grant logic. A full FIFO freezes everything, and reset
    // forces the combinational outputs low since it acts asynchronously.
    always_comb begin
        state_n    = state;
        prio_ptr_n = prio_ptr;
        owner_n    = owner_q;
        count_n    = count;
        gnt        = '0;

        if (!reset && !fifo_full) begin
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt     = pick_grant;
                        owner_n = pick_idx;
                        count_n = CW'(1);
                        if (last[pick_idx] || (BURST == 1)) begin
                            prio_ptr_n = PW'(wrap_next(int'(pick_idx), N));
                        end else begin
                            state_n = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (req[owner_q]) begin
                        gnt[owner_q] = 1'b1;
                        count_n      = count_inc;
                        if (last[owner_q] || (count_inc == CW'(BURST))) begin
                            state_n    = IDLE;
                            prio_ptr_n = PW'(wrap_next(int'(owner_q), N));
                        end
                    end else begin
                        // Owner went quiet: give up the burst without writing.
                        state_n    = IDLE;
                        prio_ptr_n = PW'(wrap_next(int'(owner_q), N));
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Steer the granted requester's beat to the FIFO; zero when idle.
    always_comb begin
        fifo_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                fifo_data = data_in[i*W +: W];
            end
        end
    end

    assign fifo_we = |gnt;
    assign busy    = (state == LOCKED);
    assign owner   = owner_q;

endmodule
